parallel_to_serial: RTL and testbench

Converts a `width`-bit parallel word, accepted over a valid/ready handshake, into a stream of one-bit values with a valid qualifier, LSB first. It is the transmit-side counterpart of `serial_to_parallel`: its serial output connects directly to that block's `serial_valid`/`serial_data` inputs. A one-word holding register lets the producer queue the next word while the current one is shifting, so consecutive words leave the block with no idle cycles between them.

---
 rtl/parallel_to_serial_pkg.sv | 14 +
 rtl/p2s_hold_reg.sv | 35 +++
 rtl/parallel_to_serial.sv | 119 +++++++++++
 tb/tb_parallel_to_serial.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/parallel_to_serial_pkg.sv
// Shared types for the parallel_to_serial block.
// FSM state encoding and counter-width helper.
package parallel_to_serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_t;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/p2s_hold_reg.sv
// One-entry holding register for parallel_to_serial.
// Push and pop are never requested together by the parent.
module p2s_hold_reg
    import parallel_to_serial_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [width-1:0] i_data,
    output logic [width-1:0] o_data,
    output logic             o_full
);

    logic [width-1:0] r_data;
    logic             r_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_push) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/parallel_to_serial.sv
// Parallel word to LSB-first serial stream with one-word holding register.
// Optional serial_last output: define PARALLEL_TO_SERIAL_LAST_EN.
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    output logic             parallel_ready,
    input  logic [width-1:0] parallel_data,
    output logic             serial_valid,
    output logic             serial_data
`ifdef PARALLEL_TO_SERIAL_LAST_EN
    ,
    output logic             serial_last
`endif
);

    localparam int            CW   = cnt_width(width);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    p2s_state_t       r_state;
    logic [width-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic             r_serial_valid;
    logic             r_serial_data;

    logic             w_accept;
    logic             w_on_last;
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_hold_full;
    logic [width-1:0] w_hold_data;
    logic [width-1:0] w_load_data;
    logic [CW-1:0]    w_count_inc;

    assign parallel_ready = rst && !w_hold_full;
    assign w_accept       = parallel_valid && parallel_ready;
    assign w_on_last      = (r_state == SHIFT) && (r_count == LAST);
    assign w_push         = w_accept && (r_state == SHIFT) && !w_on_last;
    assign w_pop          = w_on_last && w_hold_full;
    // Held word has priority; it was accepted before anything offered now.
    assign w_load         = w_on_last && (w_hold_full || w_accept);
    assign w_load_data    = w_hold_full ? w_hold_data : parallel_data;
    assign w_count_inc    = r_count + CW'(1);

    p2s_hold_reg #(
        .width (width)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_data (parallel_data),
        .o_data (w_hold_data),
        .o_full (w_hold_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_count        <= '0;
            r_serial_valid <= 1'b0;
            r_serial_data  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state        <= SHIFT;
                        r_shift        <= parallel_data;
                        r_count        <= '0;
                        r_serial_valid <= 1'b1;
                        r_serial_data  <= parallel_data[0];
                    end
                end
                SHIFT: begin
                    if (!w_on_last) begin
                        r_shift       <= r_shift >> 1;
                        r_count       <= w_count_inc;
                        r_serial_data <= r_shift[1];
                    end else if (w_load) begin
                        r_shift       <= w_load_data;
                        r_count       <= '0;
                        r_serial_data <= w_load_data[0];
                    end else begin
                        r_state        <= IDLE;
                        r_count        <= '0;
                        r_serial_valid <= 1'b0;
                        r_serial_data  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign serial_valid = r_serial_valid;
    assign serial_data  = r_serial_data;

`ifdef PARALLEL_TO_SERIAL_LAST_EN
    logic r_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b0;
        end else if ((r_state == SHIFT) && !w_on_last) begin
            r_last <= (w_count_inc == LAST);
        end else begin
            r_last <= 1'b0;
        end
    end

    assign serial_last = r_last;
`endif

endmodule

// File: tb/tb_parallel_to_serial.sv
// Randomized bench for parallel_to_serial against a bit-queue model.
// Checks serial_last too when PARALLEL_TO_SERIAL_LAST_EN is defined.
module tb_parallel_to_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         pv;
    logic         pr;
    logic [W-1:0] pd;
    logic         sv;
    logic         sd;
`ifdef PARALLEL_TO_SERIAL_LAST_EN
    logic         sl;
`endif

    always #5 clk = ~clk;

    parallel_to_serial #(
        .width (W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .parallel_valid (pv),
        .parallel_ready (pr),
        .parallel_data  (pd),
        .serial_valid   (sv),
        .serial_data    (sd)
`ifdef PARALLEL_TO_SERIAL_LAST_EN
        ,
        .serial_last    (sl)
`endif
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [1:0]   exp_q[$];
    logic [W-1:0] word_q[$];
    logic [W-1:0] rx_word;
    int           rx_cnt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: every accepted word queues W beats that must leave ASAP.
    task automatic step(input logic v, input logic [W-1:0] d,
                        output logic acc);
        logic [1:0] e;
        logic       rdy;
        @(negedge clk);
        if (sv === 1'b1) begin
            rx_word[rx_cnt] = sd;
            rx_cnt++;
            if (rx_cnt == W) begin
                rx_cnt = 0;
                if (word_q.size() == 0)
                    check("word_extra", {24'd0, rx_word}, 32'hFFFF_FFFF);
                else
                    check("word", {24'd0, rx_word}, {24'd0, word_q.pop_front()});
            end
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("valid", sv, 1);
            check("data", sd, e[0]);
`ifdef PARALLEL_TO_SERIAL_LAST_EN
            check("last", sl, e[1]);
`endif
        end else begin
            check("idle_valid", sv, 0);
            check("idle_data", sd, 0);
`ifdef PARALLEL_TO_SERIAL_LAST_EN
            check("idle_last", sl, 0);
`endif
        end
        rdy = (exp_q.size() < W);
        check("ready", pr, rdy);
        pv  = v;
        pd  = d;
        acc = v && rdy;
        if (acc) begin
            for (int i = 0; i < W; i++)
                exp_q.push_back({(i == W - 1), d[i]});
            word_q.push_back(d);
        end
    endtask

    task automatic offer(input logic [W-1:0] d);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            step(1'b1, d, acc);
            n++;
        end
        if (!acc) check("offer_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, acc);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        pv  = 1'b0;
        #1;
        check("rst_valid", sv, 0);
        check("rst_data", sd, 0);
        check("rst_ready", pr, 0);
`ifdef PARALLEL_TO_SERIAL_LAST_EN
        check("rst_last", sl, 0);
`endif
        exp_q.delete();
        word_q.delete();
        rx_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_valid", sv, 0);
            check("rst_hold_ready", pr, 0);
        end
        rst = 1'b1;
    endtask

    initial begin
        logic acc;
        rst    = 1'b0;
        pv     = 1'b0;
        pd     = '0;
        rx_cnt = 0;
        #1;
        check("por_valid", sv, 0);
        check("por_data", sd, 0);
        check("por_ready", pr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        offer(8'hA5);
        idle(12);

        offer(8'hA5);
        offer(8'h3C);
        idle(20);

        offer(8'h11);
        offer(8'h22);
        offer(8'h33);
        idle(30);

        offer(8'hFF);
        offer(8'h0F);
        idle(2);
        do_reset();
        idle(20);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0)
                step(1'b1, W'($urandom), acc);
            else
                step(1'b0, W'($urandom), acc);
        end
        idle(30);
        check("drained_words", word_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
